// File: rtl/aes_block_assembler.sv
// Byte-serial ingress for the AES datapath: packs 16 streamed bytes into one
// 128-bit state block and hands it to the cipher side over valid/ready.
module aes_block_assembler #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [7:0]   in_byte_i,
  input  logic         in_last_i,
  output logic         blk_valid_o,
  input  logic         blk_ready_i,
  output logic [127:0] blk_data_o,
  output logic [4:0]   blk_nbytes_o,
  output logic         blk_last_o
);

  localparam int unsigned NB = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned DW = NB * BW;
  localparam int unsigned CW = 4;
  localparam int unsigned NW = 5;

  typedef enum logic {FILL, FULL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic [NW-1:0] nbytes_q, nbytes_d;
  logic          last_q, last_d;
  logic          wr_en;
  logic [CW-1:0] wr_slot;
  logic          done;

  // Next-state, handshake and byte-slot write decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    nbytes_d   = nbytes_q;
    last_d     = last_q;
    in_ready_o = 1'b0;
    wr_en      = 1'b0;
    wr_slot    = cnt_q;
    done       = 1'b0;
    case (state_q)
      FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          wr_en   = 1'b1;
          wr_slot = cnt_q;
          if (cnt_q == CW'(NB - 1) || in_last_i) begin
            done     = 1'b1;
            nbytes_d = NW'(cnt_q) + NW'(1);
            last_d   = in_last_i;
            state_d  = FULL;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FULL: begin
        in_ready_o = blk_ready_i;
        if (blk_ready_i) begin
          if (in_valid_i) begin
            // Byte accepted with the block hand-off starts the next block
            wr_en   = 1'b1;
            wr_slot = '0;
            if (in_last_i) begin
              done     = 1'b1;
              nbytes_d = NW'(1);
              last_d   = 1'b1;
              cnt_d    = '0;
            end else begin
              state_d = FILL;
              cnt_d   = CW'(1);
            end
          end else begin
            state_d = FILL;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase

    // Closing a block pads every slot above the last written byte
    if (wr_en) begin
      for (int unsigned j = 0; j < NB; j++) begin
        if (CW'(j) == wr_slot) begin
          data_d[DW-1-BW*j -: BW] = in_byte_i;
        end else if (done && (CW'(j) > wr_slot)) begin
          data_d[DW-1-BW*j -: BW] = PAD_BYTE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      data_q   <= '0;
      nbytes_q <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      nbytes_q <= nbytes_d;
      last_q   <= last_d;
    end
  end

  assign blk_valid_o  = (state_q == FULL);
  assign blk_data_o   = data_q;
  assign blk_nbytes_o = nbytes_q;
  assign blk_last_o   = last_q;

endmodule

// File: tb/tb_aes_block_assembler.sv
// Scoreboard bench for aes_block_assembler: the driver predicts each block as
// bytes are accepted, a monitor compares blocks as the DUT hands them over.
module tb_aes_block_assembler;

  localparam logic [7:0] PAD = 8'h00;

  typedef struct packed {
    logic [127:0] data;
    logic [4:0]   nbytes;
    logic         last;
  } blk_t;

  logic         clk_i;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [7:0]   in_byte_i;
  logic         in_last_i;
  logic         blk_valid_o;
  logic         blk_ready_i;
  logic [127:0] blk_data_o;
  logic [4:0]   blk_nbytes_o;
  logic         blk_last_o;

  aes_block_assembler #(.PAD_BYTE(PAD)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_byte_i   (in_byte_i),
    .in_last_i   (in_last_i),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .blk_data_o  (blk_data_o),
    .blk_nbytes_o(blk_nbytes_o),
    .blk_last_o  (blk_last_o)
  );

  blk_t         exp_q[$];
  int           take_q[$];
  int           checks = 0;
  int           errors = 0;
  int           blocks_seen = 0;
  int           ready_mode = 1;
  int           stalls = 0;
  int           cyc = 0;
  logic [127:0] m_data = '0;
  int           m_cnt = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Consumer: blk_ready changes 2 time units after each rising edge
  initial begin
    blk_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      case (ready_mode)
        0:       blk_ready_i = 1'b0;
        1:       blk_ready_i = 1'b1;
        default: blk_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops and compares on each block hand-off; checks no retraction
  initial begin
    blk_t         e;
    logic         p_valid = 1'b0;
    logic         p_ready = 1'b0;
    logic         p_rst = 1'b1;
    logic [127:0] p_data = '0;
    logic [4:0]   p_nb = '0;
    logic         p_last = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!p_rst && !rst_i && p_valid && !p_ready) begin
        chk("hold_stable", {blk_valid_o, blk_nbytes_o, blk_last_o, blk_data_o},
            {1'b1, p_nb, p_last, p_data});
      end
      if (!rst_i && blk_valid_o && blk_ready_i) begin
        take_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block actual=%h required=none", blk_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("blk_data", blk_data_o, e.data);
          chk("blk_nbytes", blk_nbytes_o, e.nbytes);
          chk("blk_last", blk_last_o, e.last);
        end
        blocks_seen++;
      end
      p_valid = blk_valid_o;
      p_ready = blk_ready_i;
      p_rst   = rst_i;
      p_data  = blk_data_o;
      p_nb    = blk_nbytes_o;
      p_last  = blk_last_o;
    end
  end

  task automatic model_accept(input logic [7:0] b, input logic last);
    blk_t e;
    m_data[127-8*m_cnt -: 8] = b;
    m_cnt++;
    if (m_cnt == 16 || last) begin
      for (int j = m_cnt; j < 16; j++) m_data[127-8*j -: 8] = PAD;
      e.data   = m_data;
      e.nbytes = 5'(m_cnt);
      e.last   = last;
      exp_q.push_back(e);
      m_cnt  = 0;
      m_data = '0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    bit acc = 1'b0;
    in_valid_i = 1'b1;
    in_byte_i  = b;
    in_last_i  = last;
    while (!acc && n < 200) begin
      @(negedge clk_i);
      if (in_ready_o) acc = 1'b1;
      else begin
        stalls++;
        n++;
      end
      @(posedge clk_i);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_ready required=ready byte=%h", b);
      in_valid_i = 1'b0;
    end else begin
      model_accept(b, last);
    end
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    chk("drain_empty", 160'(exp_q.size()), 160'(0));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int c0;
    int b0;
    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    in_byte_i  = 8'h00;
    in_last_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_valid", blk_valid_o, 1'b0);
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_data", blk_data_o, 128'h0);
    chk("rst_nbytes", blk_nbytes_o, 5'd0);
    chk("rst_last", blk_last_o, 1'b0);
    @(posedge clk_i);
    #1;

    // Full 16-byte message, block visible one cycle after the final byte
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
    idle(0);
    @(negedge clk_i);
    chk("t1_latency", blk_valid_o, 1'b1);
    chk("t1_data", blk_data_o, 128'h000102030405060708090a0b0c0d0e0f);
    chk("t1_nbytes", blk_nbytes_o, 5'd16);
    chk("t1_last", blk_last_o, 1'b1);
    @(posedge clk_i);
    #1;
    drain(50);

    // Short padded block
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    idle(0);
    @(negedge clk_i);
    chk("t2_data", blk_data_o, 128'hAABBCC00_00000000_00000000_00000000);
    chk("t2_nbytes", blk_nbytes_o, 5'd3);
    chk("t2_last", blk_last_o, 1'b1);
    @(posedge clk_i);
    #1;
    drain(50);

    // 48 bytes back-to-back: one block every 16 cycles, no stalls
    stalls = 0;
    b0 = blocks_seen;
    take_q.delete();
    c0 = cyc;
    for (int i = 0; i < 48; i++) send_byte(8'(i * 3 + 7), i == 47);
    idle(0);
    drain(50);
    chk("t3_no_stall", 160'(stalls), 160'(0));
    chk("t3_blocks", 160'(blocks_seen - b0), 160'(3));
    if (take_q.size() == 3) begin
      chk("t3_take0", 160'(take_q[0] - c0), 160'(16));
      chk("t3_take1", 160'(take_q[1] - c0), 160'(32));
      chk("t3_take2", 160'(take_q[2] - c0), 160'(48));
    end else begin
      checks++;
      errors++;
      $display("FAIL t3_take_count actual=%0d required=3", take_q.size());
    end

    // Back-pressure: block held 10 cycles, then 5A rides the hand-off
    ready_mode = 0;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b0);
    idle(0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("t4_in_ready_low", {blk_valid_o, in_ready_o}, 2'b10);
    end
    @(posedge clk_i);
    #1;
    ready_mode = 1;
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 15; i++) send_byte(8'(8'h61 + i), i == 14);
    idle(0);
    drain(50);

    // Reset mid-block discards the partial bytes
    for (int i = 0; i < 7; i++) send_byte(8'(i + 1), 1'b0);
    idle(0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i  = 1'b0;
    m_cnt  = 0;
    m_data = '0;
    @(negedge clk_i);
    chk("t5_valid", blk_valid_o, 1'b0);
    chk("t5_data", blk_data_o, 128'h0);
    chk("t5_nbytes", blk_nbytes_o, 5'd0);
    chk("t5_last", blk_last_o, 1'b0);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0);
    idle(0);
    @(negedge clk_i);
    chk("t5_block", blk_data_o, 128'h101112131415161718191a1b1c1d1e1f);
    chk("t5_block_nbytes", blk_nbytes_o, 5'd16);
    @(posedge clk_i);
    #1;
    drain(50);

    // Random gaps on both sides over 1000 bytes
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      send_byte(8'($urandom), (i == 999) || ($urandom_range(0, 19) == 0));
    end
    idle(0);
    ready_mode = 1;
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
